traffic_sink: RTL and testbench
===============================

# traffic_sink

Ejection-side endpoint for the NoC and the receiving counterpart of the `traffic` packet source. It accepts flits leaving a router's local output port and reassembles packets independently per virtual channel. It returns one credit per consumed flit and counts completed packets. It flags protocol violations and asserts `done` once the expected packet count has arrived.

## Interface
Parameters:
- `NUM_VC`, 4, number of virtual channels (one-hot credit width).
- `VC_BITS`, 2, VC index width (`$clog2(NUM_VC)`).
- `DEST_BITS`, 14, destination address width.
- `LEN_BITS`, 10, packet length / packet count width.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `op`, in, 3, command: 5 = Init, all other values are no-op.
- `data`, in, 10, expected packet count, sampled on Init.
- `my_addr`, in, `DEST_BITS`, this endpoint's address.
- `flit_valid`, in, 1, a flit is present this cycle. The sink never stalls.
- `flit_head`, in, 1, head flag.
- `flit_tail`, in, 1, tail flag.
- `flit_dst`, in, `DEST_BITS`, destination field; meaningful on head flits only.
- `flit_vc`, in, `VC_BITS`, VC of the flit.
- `credit_out`, out, `NUM_VC`, one-hot credit return.
- `pkts_rcvd`, out, `LEN_BITS`, completed packets; saturates at 1023.
- `flits_rcvd`, out, 16, accepted flits; wraps modulo 2^16.
- `last_len`, out, `LEN_BITS`, flit count of the most recently completed packet.
- `err`, out, 3, sticky error flags.
  - [0] orphan body/tail.
  - [1] head on an open VC.
  - [2] head destination differs from `my_addr`.
- `done`, out, 1, high when `pkts_rcvd >= expected`.

## Operation
- Each VC has a 2-state FSM, IDLE / OPEN, and a `LEN_BITS` length counter that saturates at 1023.
- Accepting a flit (`flit_valid`, not in Init) always does two things:
  - increments `flits_rcvd`;
  - schedules a credit on `flit_vc`.
- VC in IDLE:
  - head and tail set: single-flit packet. `pkts_rcvd`+1, `last_len`=1, VC stays IDLE.
  - head only: length=1, VC goes to OPEN.
  - no head: set `err[0]`, drop the flit (no length/packet update), VC stays IDLE.
- VC in OPEN:
  - body (no head, no tail): length+1.
  - tail (no head): `pkts_rcvd`+1, `last_len`=length+1, VC goes to IDLE.
  - any head: set `err[1]` and abort the open packet; it is not counted. The flit is then processed as if the VC were IDLE (new packet starts, or single-flit packet completes).
- Head flit with `flit_dst != my_addr`: set `err[2]`. The packet is still reassembled and counted.
- Init (`op == 5`):
  - `expected <= data`;
  - clear `pkts_rcvd`, `flits_rcvd`, `last_len`, `err`, all VC FSMs (IDLE) and all length counters;
  - a flit presented in the same cycle is dropped with no credit.
- Reset: same clearing as Init, `expected <= 0`, `credit_out <= 0`.
- Reset values: `pkts_rcvd`=0, `flits_rcvd`=0, `last_len`=0, `err`=0, `credit_out`=0, `done`=1 (0 >= 0).
- Error bits are sticky until Init or reset.

## Timing
- Zero-cycle acceptance: a flit valid in cycle N is consumed at the rising edge ending N.
- Counters, `last_len`, `err` and FSM state are visible in cycle N+1.
- `credit_out` is registered: bit `flit_vc` is high for exactly cycle N+1 and zero otherwise. Back-to-back flits give consecutive credit pulses.
- `done` is combinational from registered `pkts_rcvd` and `expected`. It rises in the cycle after the final tail is accepted.
- Flits on different VCs interleave freely cycle by cycle. At most one flit arrives per cycle.
- Reset or Init asserted mid-packet discards all partial packets. No credits are issued for that cycle.

## Test plan
- Reset, then Init with `data`=3. Expect `done`=0. Send three single-flit packets (head+tail) on VC0 to `my_addr` in consecutive cycles. Expect:
  - `credit_out`=4'b0001 in 3 consecutive cycles;
  - `pkts_rcvd`=3, `done`=1, `last_len`=1, `err`=0.
- Init with `data`=2. Send interleaved 4-flit packets: VC1 H, VC2 H, VC1 B, VC2 B, VC1 B, VC2 B, VC1 T, VC2 T. Expect:
  - credits alternate 0010/0100;
  - `pkts_rcvd`=2, `last_len`=4, `flits_rcvd`=8.
- On an IDLE VC3, send a body flit. Expect `err[0]`=1, `pkts_rcvd` unchanged, `flits_rcvd`+1, credit 1000 still returned.
- Send VC0 head, then VC0 head again, then VC0 tail. Expect `err[1]`=1, `pkts_rcvd`+1 (one packet only), `last_len`=2.
- Send a head with `flit_dst`=`my_addr`^1 followed by its tail. Expect `err[2]`=1 and the packet counted.
- With VC0 OPEN, assert Init with `flit_valid`=1 (tail on VC0) and `data`=1. Expect:
  - next cycle: `credit_out`=0, `pkts_rcvd`=0, `err`=0, `done`=0;
  - a following VC0 tail sets `err[0]`.

Source files
------------

// File: rtl/traffic_sink.sv
// traffic_sink
// ------------
// Ejection-side NoC endpoint. It consumes every flit presented on the local
// output port of a router and never stalls. Packets are reassembled
// independently on each virtual channel. Each consumed flit returns one
// credit. The block counts completed packets and raises 'done' once the
// expected number of packets has arrived.
//
// Ports
//   clk         : single clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   op          : command, 5 = Init (load expected count, clear statistics)
//   data        : expected packet count, sampled on Init
//   my_addr     : address of this endpoint
//   flit_valid  : a flit is present this cycle
//   flit_head   : head flag of the flit
//   flit_tail   : tail flag of the flit
//   flit_dst    : destination field (meaningful on head flits only)
//   flit_vc     : virtual channel the flit travels on
//   credit_out  : registered one-hot credit return, one pulse per flit
//   pkts_rcvd   : completed packets, saturating
//   flits_rcvd  : accepted flits, wraps modulo 2^16
//   last_len    : flit count of the most recently completed packet
//   err         : sticky error flags
//                 [0] orphan body/tail, [1] head on open VC, [2] wrong dest
//   done        : pkts_rcvd >= expected
module traffic_sink #(
    parameter int NUM_VC    = 4,
    parameter int VC_BITS   = 2,
    parameter int DEST_BITS = 14,
    parameter int LEN_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           op,
    input  logic [LEN_BITS-1:0]  data,
    input  logic [DEST_BITS-1:0] my_addr,
    input  logic                 flit_valid,
    input  logic                 flit_head,
    input  logic                 flit_tail,
    input  logic [DEST_BITS-1:0] flit_dst,
    input  logic [VC_BITS-1:0]   flit_vc,
    output logic [NUM_VC-1:0]    credit_out,
    output logic [LEN_BITS-1:0]  pkts_rcvd,
    output logic [15:0]          flits_rcvd,
    output logic [LEN_BITS-1:0]  last_len,
    output logic [2:0]           err,
    output logic                 done
);

    localparam logic [2:0] OP_INIT = 3'd5;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_OPEN = 1'b1
    } vc_state_t;

    vc_state_t           vc_state     [NUM_VC];
    vc_state_t           vc_state_nxt [NUM_VC];
    logic [LEN_BITS-1:0] vc_len       [NUM_VC];
    logic [LEN_BITS-1:0] vc_len_nxt   [NUM_VC];

    logic [LEN_BITS-1:0] expected;
    logic [LEN_BITS-1:0] expected_nxt;
    logic [LEN_BITS-1:0] pkts_nxt;
    logic [15:0]         flits_nxt;
    logic [LEN_BITS-1:0] last_nxt;
    logic [2:0]          err_nxt;
    logic [NUM_VC-1:0]   credit_nxt;
    logic                is_init;

    // Counters of LEN_BITS width stick at their all-ones value instead of
    // wrapping back to zero.
    function automatic logic [LEN_BITS-1:0] sat_inc(input logic [LEN_BITS-1:0] v);
        return (&v) ? v : v + LEN_BITS'(1);
    endfunction

    assign is_init = (op == OP_INIT);

    // Next-state logic for every VC FSM, the length counters, the statistics
    // and the credit pulse. Init wins over a flit in the same cycle, so that
    // flit is dropped silently and no credit is returned for it.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_state_nxt[i] = vc_state[i];
            vc_len_nxt[i]   = vc_len[i];
        end
        expected_nxt = expected;
        pkts_nxt     = pkts_rcvd;
        flits_nxt    = flits_rcvd;
        last_nxt     = last_len;
        err_nxt      = err;
        credit_nxt   = '0;

        if (is_init) begin
            expected_nxt = data;
            pkts_nxt     = '0;
            flits_nxt    = '0;
            last_nxt     = '0;
            err_nxt      = '0;
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state_nxt[i] = VC_IDLE;
                vc_len_nxt[i]   = '0;
            end
        end else if (flit_valid) begin
            flits_nxt           = flits_rcvd + 16'd1;
            credit_nxt[flit_vc] = 1'b1;

            if (flit_head && (flit_dst != my_addr)) begin
                err_nxt[2] = 1'b1;
            end

            if (flit_head) begin
                // A head on an open VC abandons the partial packet; the head
                // itself is then handled exactly as on an idle VC.
                if (vc_state[flit_vc] == VC_OPEN) begin
                    err_nxt[1] = 1'b1;
                end
                if (flit_tail) begin
                    pkts_nxt              = sat_inc(pkts_rcvd);
                    last_nxt              = LEN_BITS'(1);
                    vc_state_nxt[flit_vc] = VC_IDLE;
                    vc_len_nxt[flit_vc]   = '0;
                end else begin
                    vc_state_nxt[flit_vc] = VC_OPEN;
                    vc_len_nxt[flit_vc]   = LEN_BITS'(1);
                end
            end else if (vc_state[flit_vc] == VC_IDLE) begin
                err_nxt[0] = 1'b1;
            end else if (flit_tail) begin
                pkts_nxt              = sat_inc(pkts_rcvd);
                last_nxt              = sat_inc(vc_len[flit_vc]);
                vc_state_nxt[flit_vc] = VC_IDLE;
                vc_len_nxt[flit_vc]   = '0;
            end else begin
                vc_len_nxt[flit_vc] = sat_inc(vc_len[flit_vc]);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state[i] <= VC_IDLE;
                vc_len[i]   <= '0;
            end
            expected   <= '0;
            pkts_rcvd  <= '0;
            flits_rcvd <= '0;
            last_len   <= '0;
            err        <= '0;
            credit_out <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state[i] <= vc_state_nxt[i];
                vc_len[i]   <= vc_len_nxt[i];
            end
            expected   <= expected_nxt;
            pkts_rcvd  <= pkts_nxt;
            flits_rcvd <= flits_nxt;
            last_len   <= last_nxt;
            err        <= err_nxt;
            credit_out <= credit_nxt;
        end
    end

    assign done = (pkts_rcvd >= expected);

endmodule

// File: tb/tb_traffic_sink.sv
// tb_traffic_sink
// ---------------
// Scoreboard bench for traffic_sink. The stimulus process drives one cycle at
// a time, advances a packet-level reference model and queues the outputs it
// expects after that clock edge. An independent monitor pops each entry and
// compares it against the DUT outputs on the falling edge.
module tb_traffic_sink;

    localparam logic [13:0] MY_ADDR = 14'h1A5;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [9:0]  data;
    logic        flit_valid;
    logic        flit_head;
    logic        flit_tail;
    logic [13:0] flit_dst;
    logic [1:0]  flit_vc;
    logic [3:0]  credit_out;
    logic [9:0]  pkts_rcvd;
    logic [15:0] flits_rcvd;
    logic [9:0]  last_len;
    logic [2:0]  err;
    logic        done;

    traffic_sink #(
        .NUM_VC    (4),
        .VC_BITS   (2),
        .DEST_BITS (14),
        .LEN_BITS  (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .data       (data),
        .my_addr    (MY_ADDR),
        .flit_valid (flit_valid),
        .flit_head  (flit_head),
        .flit_tail  (flit_tail),
        .flit_dst   (flit_dst),
        .flit_vc    (flit_vc),
        .credit_out (credit_out),
        .pkts_rcvd  (pkts_rcvd),
        .flits_rcvd (flits_rcvd),
        .last_len   (last_len),
        .err        (err),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  credit;
        logic [9:0]  pkts;
        logic [15:0] flits;
        logic [9:0]  last;
        logic [2:0]  err;
        logic        done;
    } expect_t;

    expect_t exp_q[$];

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: packet-level bookkeeping per VC
    int m_expected = 0;
    int m_pkts     = 0;
    int m_flits    = 0;
    int m_last     = 0;
    int m_err      = 0;
    int m_credit   = 0;
    bit m_open [4];
    int m_len  [4];

    function automatic int min1023(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    function automatic void clearModel();
        m_pkts  = 0;
        m_flits = 0;
        m_last  = 0;
        m_err   = 0;
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 1'b0;
            m_len[i]  = 0;
        end
    endfunction

    function automatic void updateModel(input bit r, input int o, input int d,
                                        input bit v, input bit h, input bit t,
                                        input int dst, input int vc);
        m_credit = 0;
        if (r) begin
            clearModel();
            m_expected = 0;
        end else if (o == 5) begin
            clearModel();
            m_expected = d;
        end else if (v) begin
            m_flits  = (m_flits + 1) % 65536;
            m_credit = 1 << vc;
            if (h) begin
                if (m_open[vc]) m_err = m_err | 2;
                if (dst != int'(MY_ADDR)) m_err = m_err | 4;
                m_open[vc] = 1'b0;
                if (t) begin
                    m_pkts = min1023(m_pkts + 1);
                    m_last = 1;
                end else begin
                    m_open[vc] = 1'b1;
                    m_len[vc]  = 1;
                end
            end else if (!m_open[vc]) begin
                m_err = m_err | 1;
            end else if (t) begin
                m_pkts     = min1023(m_pkts + 1);
                m_last     = min1023(m_len[vc] + 1);
                m_open[vc] = 1'b0;
            end else begin
                m_len[vc] = min1023(m_len[vc] + 1);
            end
        end
    endfunction

    task automatic checkField(input string name, input logic [31:0] act,
                              input logic [31:0] req);
        check_count++;
        if (act === req) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkField("credit_out", 32'(credit_out), 32'(e.credit));
        checkField("pkts_rcvd",  32'(pkts_rcvd),  32'(e.pkts));
        checkField("flits_rcvd", 32'(flits_rcvd), 32'(e.flits));
        checkField("last_len",   32'(last_len),   32'(e.last));
        checkField("err",        32'(err),        32'(e.err));
        checkField("done",       32'(done),       32'(e.done));
    endtask

    // Drive one cycle, advance the model, and queue the outputs expected
    // once the DUT has taken the following rising edge.
    task automatic applyStimulus(input bit r, input logic [2:0] o, input logic [9:0] d,
                                 input bit v, input bit h, input bit t,
                                 input logic [13:0] dst, input logic [1:0] vc);
        expect_t e;
        @(negedge clk);
        rst        = r;
        op         = o;
        data       = d;
        flit_valid = v;
        flit_head  = h;
        flit_tail  = t;
        flit_dst   = dst;
        flit_vc    = vc;
        updateModel(r, int'(o), int'(d), v, h, t, int'(dst), int'(vc));
        e.credit = 4'(m_credit);
        e.pkts   = 10'(m_pkts);
        e.flits  = 16'(m_flits);
        e.last   = 10'(m_last);
        e.err    = 3'(m_err);
        e.done   = (m_pkts >= m_expected);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0, MY_ADDR, 2'd0);
    endtask

    task automatic sendFlit(input logic [1:0] vc, input bit h, input bit t);
        applyStimulus(1'b0, 3'd0, 10'd0, 1'b1, h, t, MY_ADDR, vc);
    endtask

    task automatic doInit(input logic [9:0] d);
        applyStimulus(1'b0, 3'd5, d, 1'b0, 1'b0, 1'b0, MY_ADDR, 2'd0);
    endtask

    // Monitor: compares whenever the stimulus side has queued a response.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic [13:0] rdst;
        int          ropv;
        rst = 1'b0; op = 3'd0; data = 10'd0; flit_valid = 1'b0;
        flit_head = 1'b0; flit_tail = 1'b0; flit_dst = MY_ADDR; flit_vc = 2'd0;

        applyStimulus(1'b1, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0, MY_ADDR, 2'd0);
        applyStimulus(1'b1, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0, MY_ADDR, 2'd0);
        idle();

        // Three single-flit packets back to back on VC0
        doInit(10'd3);
        idle();
        for (int i = 0; i < 3; i++) sendFlit(2'd0, 1'b1, 1'b1);
        idle();

        // Two interleaved 4-flit packets on VC1 and VC2
        doInit(10'd2);
        sendFlit(2'd1, 1'b1, 1'b0); sendFlit(2'd2, 1'b1, 1'b0);
        sendFlit(2'd1, 1'b0, 1'b0); sendFlit(2'd2, 1'b0, 1'b0);
        sendFlit(2'd1, 1'b0, 1'b0); sendFlit(2'd2, 1'b0, 1'b0);
        sendFlit(2'd1, 1'b0, 1'b1); sendFlit(2'd2, 1'b0, 1'b1);
        idle();

        // Orphan body on idle VC3
        sendFlit(2'd3, 1'b0, 1'b0);

        // Head on an open VC aborts the first packet
        sendFlit(2'd0, 1'b1, 1'b0);
        sendFlit(2'd0, 1'b1, 1'b0);
        sendFlit(2'd0, 1'b0, 1'b1);

        // Wrong destination is flagged but the packet still counts
        applyStimulus(1'b0, 3'd0, 10'd0, 1'b1, 1'b1, 1'b0, MY_ADDR ^ 14'd1, 2'd1);
        sendFlit(2'd1, 1'b0, 1'b1);
        idle();

        // Init with a flit in the same cycle drops the flit and the open packet
        sendFlit(2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd5, 10'd1, 1'b1, 1'b0, 1'b1, MY_ADDR, 2'd0);
        sendFlit(2'd0, 1'b0, 1'b1);
        idle();

        // Packet counter saturation
        doInit(10'd1000);
        for (int i = 0; i < 1030; i++) sendFlit(2'd0, 1'b1, 1'b1);
        idle();

        // Length counter saturation on one very long packet
        doInit(10'd1);
        sendFlit(2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 1030; i++) sendFlit(2'd2, 1'b0, 1'b0);
        sendFlit(2'd2, 1'b0, 1'b1);
        idle();

        // Randomized traffic with occasional Init, reset and wrong addresses
        doInit(10'd40);
        for (int i = 0; i < 2000; i++) begin
            ropv = int'($urandom_range(0, 99));
            rdst = ($urandom_range(0, 9) == 0) ? 14'($urandom) : MY_ADDR;
            if (ropv < 1) begin
                applyStimulus(1'b1, 3'($urandom), 10'($urandom), 1'($urandom),
                              1'($urandom), 1'($urandom), rdst, 2'($urandom));
            end else if (ropv < 3) begin
                applyStimulus(1'b0, 3'd5, 10'($urandom_range(0, 60)), 1'($urandom),
                              1'($urandom), 1'($urandom), rdst, 2'($urandom));
            end else begin
                logic [2:0] nop;
                nop = 3'($urandom);
                if (nop == 3'd5) nop = 3'd0;
                applyStimulus(1'b0, nop, 10'($urandom), ($urandom_range(0, 9) < 7),
                              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
                              rdst, 2'($urandom));
            end
        end
        idle();

        // Let the monitor drain the scoreboard, within a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
